// File: rtl/asi_rw_arb.sv
// asi_rw_arb: grants the shared user memory port to the write or read path, holding it for whole bursts
module asi_rw_arb #(
  parameter int MAX_WAIT = 16,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = $clog2(MAX_WAIT + HOLD_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cfg_mode,
  input  logic       w_req,
  input  logic       w_busy,
  input  logic       r_req,
  input  logic       r_busy,
  output logic       wgranted,
  output logic       rgranted,
  output logic [1:0] arb_state,
  output logic       starve_evt
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WGNT = 2'd1, ST_RGNT = 2'd2} st_t;
  localparam logic [CNT_W-1:0] MW = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] HM = CNT_W'(HOLD_MAX);
  st_t             state, nxt, nxt_i, x_st;
  logic [1:0]      mode_q;
  logic            last_owner;
  logic            served;
  logic [CNT_W-1:0] wait_cnt, hold_cnt;
  logic            own_w, o_req, o_busy, x_req, x_hi, fixed, rr, forced, rel, rel_a;
  assign arb_state = state;
  always_comb begin
    own_w  = state == ST_WGNT;
    o_req  = own_w ? w_req : r_req;
    o_busy = own_w ? w_busy : r_busy;
    x_req  = own_w ? r_req : w_req;
    x_st   = own_w ? ST_RGNT : ST_WGNT;
    x_hi   = own_w ? mode_q == 2'd2 : mode_q == 2'd1;
    fixed  = mode_q == 2'd1 || mode_q == 2'd2;
    rr     = !fixed;
    forced = (fixed && wait_cnt >= MW) || hold_cnt >= HM;
    rel_a  = !o_busy && x_req && forced;
    rel    = !o_busy && ((x_req && (forced || (rr && served) || x_hi)) || !o_req);
    // on a tie last_owner=1 (read) hands the port to write
    nxt_i  = (w_req && r_req) ? (cfg_mode == 2'd1 ? ST_WGNT :
                                 cfg_mode == 2'd2 ? ST_RGNT :
                                 last_owner ? ST_WGNT : ST_RGNT) :
             w_req ? ST_WGNT : r_req ? ST_RGNT : ST_IDLE;
    nxt    = state == ST_IDLE ? nxt_i : rel ? (x_req ? x_st : ST_IDLE) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wgranted   <= 1'b0;
      rgranted   <= 1'b0;
      starve_evt <= 1'b0;
      mode_q     <= 2'd0;
      last_owner <= 1'b1;
      served     <= 1'b0;
      wait_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= nxt;
      wgranted   <= nxt == ST_WGNT;
      rgranted   <= nxt == ST_RGNT;
      starve_evt <= state != ST_IDLE && rel_a;
      if (state == ST_IDLE) mode_q <= cfg_mode;
      if (nxt != state) begin
        served   <= 1'b0;
        wait_cnt <= '0;
        hold_cnt <= '0;
        if (state != ST_IDLE) last_owner <= state == ST_RGNT;
      end else if (state != ST_IDLE) begin
        served   <= served | o_busy;
        wait_cnt <= (fixed && x_req && wait_cnt < MW) ? wait_cnt + 1'b1 : wait_cnt;
        hold_cnt <= (!served && x_req && hold_cnt < HM) ? hold_cnt + 1'b1 : hold_cnt;
      end
    end
  end
endmodule

// File: tb/tb_asi_rw_arb.sv
// tb_asi_rw_arb: directed scoreboard bench for asi_rw_arb; expected {wgranted,rgranted,arb_state,starve_evt}
module tb_asi_rw_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       w_req = 1'b0, w_busy = 1'b0, r_req = 1'b0, r_busy = 1'b0;
  logic       wgranted, rgranted, starve_evt;
  logic [1:0] arb_state;
  logic [4:0] q[$];
  int         checks = 0;
  int         errors = 0;
  localparam logic [4:0] I  = 5'b00000;
  localparam logic [4:0] W  = 5'b10010;
  localparam logic [4:0] R  = 5'b01100;
  localparam logic [4:0] RS = 5'b01101;

  asi_rw_arb dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
    .w_req(w_req), .w_busy(w_busy), .r_req(r_req), .r_busy(r_busy),
    .wgranted(wgranted), .rgranted(rgranted), .arb_state(arb_state), .starve_evt(starve_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    logic [4:0] got, exp_v;
    got   = {wgranted, rgranted, arb_state, starve_evt};
    exp_v = q.pop_front();
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp_v);
    end
  endtask

  task automatic cyc(input string tag, input logic w, input logic wb, input logic r, input logic rb,
                     input logic [4:0] e);
    w_req = w; w_busy = wb; r_req = r; r_busy = rb;
    q.push_back(e);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst_n = 1'b0; cfg_mode = m;
    w_req = 1'b0; w_busy = 1'b0; r_req = 1'b0; r_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.push_back(I);
    chk("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // single write requester, burst of 4, return to idle
    do_reset(2'd0);
    cyc("idle", 0, 0, 0, 0, I);
    cyc("w_grant", 1, 0, 0, 0, W);
    cyc("w_burst", 1, 1, 0, 0, W);
    for (int k = 0; k < 3; k++) cyc("w_burst", 0, 1, 0, 0, W);
    cyc("w_release_idle", 0, 0, 0, 0, I);
    // round-robin tie: write first, then read, then write
    do_reset(2'd0);
    cyc("rr_tie_w", 1, 0, 1, 0, W);
    for (int k = 0; k < 3; k++) cyc("rr_w_burst", 1, 1, 1, 0, W);
    cyc("rr_to_r", 0, 0, 1, 0, R);
    for (int k = 0; k < 3; k++) cyc("rr_r_burst", 1, 0, 1, 1, R);
    cyc("rr_to_w", 1, 0, 1, 0, W);
    cyc("rr_idle", 0, 0, 0, 0, I);
    // write priority, back-to-back bursts starve read until wait limit
    do_reset(2'd1);
    cyc("m1_grant_w", 1, 0, 1, 0, W);
    for (int k = 0; k < 19; k++) cyc("m1_hold_w", 1, (k % 5) != 4, 1, 0, W);
    cyc("m1_starve", 1, 0, 1, 0, RS);
    cyc("m1_no_repulse", 0, 0, 1, 1, R);
    cyc("m1_idle", 0, 0, 0, 0, I);
    // read priority: idle low-priority owner yields; busy owner keeps
    do_reset(2'd2);
    cyc("m2_grant_w", 1, 0, 0, 0, W);
    cyc("m2_yield_r", 1, 0, 1, 0, R);
    cyc("m2_idle", 0, 0, 0, 0, I);
    cyc("m2_grant_w2", 1, 0, 0, 0, W);
    cyc("m2_busy_keep", 1, 1, 1, 0, W);
    cyc("m2_busy_keep", 1, 1, 1, 0, W);
    cyc("m2_yield_r2", 1, 0, 1, 0, R);
    cyc("m2_idle2", 0, 0, 0, 0, I);
    // round-robin no-progress timeout
    do_reset(2'd0);
    cyc("hold_grant_w", 1, 0, 0, 0, W);
    for (int k = 0; k < 8; k++) cyc("hold_wait", 1, 0, 1, 0, W);
    cyc("hold_forced", 1, 0, 1, 0, RS);
    cyc("hold_idle", 0, 0, 0, 0, I);
    // asynchronous reset mid-burst
    do_reset(2'd0);
    cyc("ar_grant_w", 1, 0, 0, 0, W);
    cyc("ar_burst", 1, 1, 0, 0, W);
    #2 rst_n = 1'b0;
    #1;
    q.push_back(I);
    chk("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    w_req = 1'b0; w_busy = 1'b0;
    cyc("ar_after_idle", 0, 0, 0, 0, I);
    cyc("ar_tie_w", 1, 0, 1, 0, W);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
